// File: rtl/reaction_time_accumulator_pkg.sv
// Shared constants for the reaction-time accumulator: sample width, saturation
// ceiling and FSM state encodings.
package reaction_time_accumulator_pkg;

  localparam int              TIME_W   = 13;
  localparam logic [TIME_W-1:0] TIME_MAX = 13'h1FFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder_13bit.sv
// 13-bit ripple-carry adder with unsigned carry-out and signed overflow.
module full_adder_13bit
  import reaction_time_accumulator_pkg::*;
(
  input  logic [TIME_W-1:0] x,
  input  logic [TIME_W-1:0] y,
  input  logic              cin,
  output logic [TIME_W-1:0] sout,
  output logic              cout,
  output logic              overflow
);

  logic carry;
  logic c_msb;

  // Carry ripples through a variable so the chain is not one self-referencing vector.
  always_comb begin
    sout  = '0;
    carry = cin;
    c_msb = 1'b0;
    for (int i = 0; i < TIME_W; i++) begin
      if (i == TIME_W - 1) c_msb = carry;
      sout[i] = x[i] ^ y[i] ^ carry;
      carry   = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout     = carry;
    overflow = carry ^ c_msb;
  end

endmodule

// File: rtl/reaction_time_accumulator.sv
// Collects N_TRIALS reaction times into a saturating total and reports the
// integer average once the round is complete.
module reaction_time_accumulator
  import reaction_time_accumulator_pkg::*;
#(
  parameter int N_TRIALS    = 4,
  parameter int LOG2_TRIALS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [TIME_W-1:0] sample_ms,
  output logic              sample_ready,
  output logic [3:0]        trial_count,
  output logic [TIME_W-1:0] total_ms,
  output logic [TIME_W-1:0] average_ms,
  output logic              saturated,
  output logic              done
);

  logic [1:0]        state;
  logic [TIME_W-1:0] add_sum;
  logic              add_cout;
  logic              unused_ovf;
  logic [TIME_W-1:0] sum_nxt;
  logic [3:0]        cnt_nxt;
  logic              xfer;
  logic              last;

  full_adder_13bit u_add (
    .x        (total_ms),
    .y        (sample_ms),
    .cin      (1'b0),
    .sout     (add_sum),
    .cout     (add_cout),
    .overflow (unused_ovf)
  );

  assign sample_ready = (state == ST_ACCUM);
  assign done         = (state == ST_DONE);

  // start wins over a same-cycle sample, so the sample is dropped.
  assign xfer    = sample_ready & sample_valid & ~start;
  assign sum_nxt = (saturated | add_cout) ? TIME_MAX : add_sum;
  assign cnt_nxt = trial_count + 4'd1;
  assign last    = (cnt_nxt == 4'(N_TRIALS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      trial_count <= '0;
      total_ms    <= '0;
      average_ms  <= '0;
      saturated   <= 1'b0;
    end else if (start) begin
      state       <= ST_ACCUM;
      trial_count <= '0;
      total_ms    <= '0;
      saturated   <= 1'b0;
    end else if (xfer) begin
      total_ms    <= sum_nxt;
      saturated   <= saturated | add_cout;
      trial_count <= cnt_nxt;
      if (last) begin
        state      <= ST_DONE;
        average_ms <= sum_nxt >> LOG2_TRIALS;
      end
    end else if (state != ST_IDLE && state != ST_ACCUM && state != ST_DONE) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_reaction_time_accumulator.sv
// Directed test-plan rounds followed by random traffic, all checked against a
// sum-of-accepted-samples reference model.
module tb_reaction_time_accumulator;

  localparam int N  = 4;
  localparam int LG = 2;
  localparam int M_IDLE = 0, M_ACCUM = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [12:0] sample_ms = '0;
  logic        sample_ready;
  logic [3:0]  trial_count;
  logic [12:0] total_ms;
  logic [12:0] average_ms;
  logic        saturated;
  logic        done;

  reaction_time_accumulator #(.N_TRIALS(N), .LOG2_TRIALS(LG)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .sample_ms    (sample_ms),
    .sample_ready (sample_ready),
    .trial_count  (trial_count),
    .total_ms     (total_ms),
    .average_ms   (average_ms),
    .saturated    (saturated),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: true (unbounded) sum of accepted samples this round
  int m_mode = M_IDLE;
  int m_sum  = 0;
  int m_cnt  = 0;
  int m_avg  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clip(input int s);
    return (s > 8191) ? 8191 : s;
  endfunction

  task automatic model(input bit r, input bit s, input bit v, input int smp);
    if (r) begin
      m_mode = M_IDLE; m_sum = 0; m_cnt = 0; m_avg = 0;
    end else if (s) begin
      m_mode = M_ACCUM; m_sum = 0; m_cnt = 0;
    end else if (m_mode == M_ACCUM && v) begin
      m_sum += smp;
      m_cnt++;
      if (m_cnt == N) begin
        m_mode = M_DONE;
        m_avg  = clip(m_sum) / N;
      end
    end
  endtask

  task automatic check_all();
    chk("ready", int'(sample_ready), int'(m_mode == M_ACCUM));
    chk("done",  int'(done),         int'(m_mode == M_DONE));
    chk("count", int'(trial_count),  m_cnt);
    chk("total", int'(total_ms),     clip(m_sum));
    chk("sat",   int'(saturated),    int'(m_sum > 8191));
    if (m_mode != M_ACCUM) chk("avg", int'(average_ms), m_avg);
  endtask

  task automatic step(input bit r, input bit s, input bit v, input int smp);
    logic [12:0] sv;
    sv = smp[12:0];
    rst = r; start = s; sample_valid = v; sample_ms = sv;
    @(posedge clk);
    model(r, s, v, int'(sv));
    #1;
    check_all();
  endtask

  task automatic round4(input int a, input int b, input int c, input int d, input int gap);
    int smp[4];
    smp = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, smp[i]);
      chk("step_count", int'(trial_count), i + 1);
      for (int g = 0; g < gap; g++) step(0, 0, 0, 4321);
    end
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0);
    chk("rst_total", int'(total_ms), 0);
    chk("rst_ready", int'(sample_ready), 0);

    // basic round
    step(0, 1, 0, 0);
    round4(250, 300, 200, 250, 0);
    chk("basic_done",  int'(done), 1);
    chk("basic_total", int'(total_ms), 1000);
    chk("basic_avg",   int'(average_ms), 250);
    chk("basic_sat",   int'(saturated), 0);
    step(0, 0, 1, 77);
    chk("done_hold", int'(total_ms), 1000);

    // saturation
    step(0, 1, 0, 0);
    step(0, 0, 1, 4000);
    step(0, 0, 1, 4000);
    step(0, 0, 1, 500);
    chk("sat3_total", int'(total_ms), 8191);
    chk("sat3_flag",  int'(saturated), 1);
    step(0, 0, 1, 100);
    chk("sat4_total", int'(total_ms), 8191);
    chk("sat4_avg",   int'(average_ms), 2047);

    // gapped valid
    step(0, 1, 0, 0);
    round4(250, 300, 200, 250, 3);
    chk("gap_total", int'(total_ms), 1000);
    chk("gap_avg",   int'(average_ms), 250);

    // restart mid-round, start beats the coincident sample
    step(0, 1, 0, 0);
    step(0, 0, 1, 100);
    step(0, 0, 1, 200);
    step(0, 1, 1, 999);
    chk("restart_total", int'(total_ms), 0);
    chk("restart_count", int'(trial_count), 0);
    round4(50, 50, 50, 50, 0);
    chk("restart_sum", int'(total_ms), 200);
    chk("restart_avg", int'(average_ms), 50);

    // reset mid-round, then IDLE ignores samples
    step(0, 1, 0, 0);
    step(0, 0, 1, 10);
    step(0, 0, 1, 20);
    step(0, 0, 1, 30);
    chk("pre_rst_count", int'(trial_count), 3);
    step(1, 0, 1, 40);
    chk("mid_rst_count", int'(trial_count), 0);
    chk("mid_rst_total", int'(total_ms), 0);
    step(0, 0, 1, 123);
    chk("idle_ignore", int'(trial_count), 0);

    // zero and edge samples
    step(0, 1, 0, 0);
    round4(0, 0, 0, 8191, 0);
    chk("edge_total", int'(total_ms), 8191);
    chk("edge_sat",   int'(saturated), 0);
    chk("edge_avg",   int'(average_ms), 2047);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v;
      int smp;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 6);
      v   = ($urandom_range(0, 99) < 60);
      smp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191))
                                        : int'($urandom_range(0, 800));
      step(r, s, v, smp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_time_accumulator.md
Name: reaction_time_accumulator

Overview:
- Downstream consumer of the 13-bit ripple adder (full_adder_13bit).
- Accepts per-trial reaction times in milliseconds from the reaction timer over a valid/ready handshake.
- Accumulates N_TRIALS samples into a saturating 13-bit total, then presents the total and the integer average to the score display logic.
- The adder instance performs all additions; this block supplies its operands and registers its results.

Parameters:
- N_TRIALS, 4, number of samples per round; must be a power of two, range 2..8.
- LOG2_TRIALS, 2, log2(N_TRIALS); used as the shift amount for the average.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a new round.
- sample_valid  input  1  a sample is presented on sample_ms.
- sample_ms  input  13  reaction time, unsigned ms (0..8191).
- sample_ready  output  1  block will accept a sample this cycle.
- trial_count  output  4  samples accepted in the current round.
- total_ms  output  13  running sum, saturating.
- average_ms  output  13  total_ms >> LOG2_TRIALS; valid while done=1.
- saturated  output  1  sum exceeded 8191 during this round.
- done  output  1  round complete; results stable.

Behaviour:
- Reset: rst=1 at a rising edge forces the following in the next cycle, regardless of state, including mid-round.
  - State = IDLE.
  - trial_count=0, total_ms=0, average_ms=0.
  - saturated=0, done=0, sample_ready=0.
- States: IDLE, ACCUM, DONE; 2-bit encoding.
- IDLE:
  - sample_ready=0; samples are ignored.
  - start=1 -> ACCUM; clears trial_count, total_ms, saturated.
- ACCUM:
  - sample_ready=1.
  - A transfer occurs when sample_valid & sample_ready are both 1 in the same cycle.
  - On a transfer:
    - Adder inputs: X=total_ms, Y=sample_ms, Cin=0.
    - Next cycle: total_ms = Sout if Cout=0, else 13'h1FFF with saturated set.
    - Once saturated=1, total_ms holds at 13'h1FFF for the rest of the round.
    - trial_count increments.
    - The adder's Overflow output (signed) is unused.
  - Latency: total_ms and trial_count reflect a sample one cycle after the transfer.
  - Transfer bringing trial_count to N_TRIALS -> DONE; sample_ready drops in that same next cycle.
  - start=1 while in ACCUM restarts the round: same clears as from IDLE, state stays ACCUM. start has priority over a simultaneous transfer, which is discarded.
  - sample_valid=0 cycles: no change.
- DONE:
  - done=1, sample_ready=0.
  - average_ms = total_ms >> LOG2_TRIALS, registered on entry to DONE, so done and average_ms assert together.
  - Outputs hold until start (-> ACCUM, done cleared the next cycle) or rst.
- sample_ms=0 is a legal sample and counts as a trial.
- trial_count never exceeds N_TRIALS.
- No combinational path from sample_valid to sample_ready; sample_ready is a function of state only.

Decomposition:
- Shared include header (guarded with `ifndef, same as the other blocks):
  - State encodings ST_IDLE=0, ST_ACCUM=1, ST_DONE=2.
  - TIME_W=13.
  - TIME_MAX=13'h1FFF.
- Sub-module: one instance of full_adder_13bit, reused unchanged.
- Everything else stays inline: FSM, count register, saturation mux.

Test Plan:
- Basic round: rst, start, samples 250, 300, 200, 250 with valid held -> one cycle after the 4th transfer: done=1, total_ms=1000, average_ms=250, saturated=0, trial_count=4.
- Saturation: samples 4000, 4000, 500, 100 -> total_ms=8191 after the 3rd sample and stays 8191 after the 4th; saturated=1, average_ms=2047.
- Gapped valid: same samples as the basic round with sample_valid deasserted 3 cycles between each -> identical results; trial_count steps 1, 2, 3, 4 only on transfers.
- Restart mid-round: after 2 samples (100, 200), start=1 together with sample_valid (sample 999) -> next cycle total_ms=0, trial_count=0; then 4×50 -> total_ms=200, average_ms=50.
- Reset mid-round: rst during ACCUM with trial_count=3 -> next cycle every output is 0 and the state is IDLE; a sample presented in IDLE is not accepted (sample_ready=0).
- Zero and edge samples: 0, 0, 0, 8191 -> total_ms=8191, saturated=0 (Cout never set), average_ms=2047.
